// File: rtl/sha256_core_arbiter.sv
// rtl/sha256_core_arbiter.sv - two-requester block arbiter for a SHA-256 core with per-message lock
// Optional idle-owner lock timeout is built only when SHA_ARB_TIMEOUT_EN is defined.
module sha256_core_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic         iClk,
    input  logic         iReset,
    input  logic [1:0]   iReqValid,
    input  logic [511:0] iReqBlock0,
    input  logic [511:0] iReqBlock1,
    input  logic [1:0]   iReqLast,
    output logic [1:0]   oReqReady,
    output logic         oCoreLoad,
    output logic [511:0] oCoreMessage,
    output logic         oCoreFirst,
    input  logic         iCoreDone,
    input  logic [255:0] iCoreDigest,
    output logic [255:0] oDigest,
    output logic [1:0]   oDigestValid,
    output logic         oBusy,
    output logic         oOwner,
    output logic [15:0]  oBlockCnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t         state_q, state_d;
    logic           lock_q, lock_d;
    logic           last_q, last_d;
    logic           first_q, first_d;
    logic           owner_q, owner_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [511:0]   msg_q, msg_d;
    logic [255:0]   digest_q, digest_d;
    logic [1:0]     dv_q, dv_d;

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  tmo_q, tmo_d;
`endif

    logic grant;
    logic grant_valid;
    logic accept;

    // While locked only the owner may continue; otherwise a tie goes to the requester not served last.
    always_comb begin
        grant       = owner_q;
        grant_valid = 1'b0;
        if (lock_q) begin
            grant_valid = iReqValid[owner_q];
        end else if (&iReqValid) begin
            grant       = ~owner_q;
            grant_valid = 1'b1;
        end else if (iReqValid[0]) begin
            grant       = 1'b0;
            grant_valid = 1'b1;
        end else if (iReqValid[1]) begin
            grant       = 1'b1;
            grant_valid = 1'b1;
        end
    end

    assign accept    = (state_q == S_IDLE) && grant_valid && !iReset;
    assign oReqReady = accept ? (2'b01 << grant) : 2'b00;

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        last_d   = last_q;
        first_d  = first_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        msg_d    = msg_q;
        digest_d = digest_q;
        dv_d     = 2'b00;
`ifdef SHA_ARB_TIMEOUT_EN
        tmo_d    = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    msg_d   = grant ? iReqBlock1 : iReqBlock0;
                    last_d  = iReqLast[grant];
                    first_d = !lock_q;
                    lock_d  = 1'b1;
                    owner_d = grant;
                    if (!lock_q) begin
                        cnt_d = 16'd1;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    state_d = S_LOAD;
                end
`ifdef SHA_ARB_TIMEOUT_EN
                else if (lock_q && !iReqValid[owner_q]) begin
                    // Abandoned message: release the lock without reporting a digest.
                    if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        lock_d = 1'b0;
                        cnt_d  = 16'd0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
`endif
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (iCoreDone) begin
                    state_d = S_IDLE;
                    if (last_q) begin
                        digest_d = iCoreDigest;
                        dv_d     = 2'b01 << owner_q;
                        lock_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q  <= S_IDLE;
            lock_q   <= 1'b0;
            last_q   <= 1'b0;
            first_q  <= 1'b0;
            owner_q  <= 1'b1;
            cnt_q    <= 16'd0;
            msg_q    <= '0;
            digest_q <= '0;
            dv_q     <= 2'b00;
`ifdef SHA_ARB_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            last_q   <= last_d;
            first_q  <= first_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            msg_q    <= msg_d;
            digest_q <= digest_d;
            dv_q     <= dv_d;
`ifdef SHA_ARB_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign oCoreLoad    = (state_q == S_LOAD);
    assign oCoreFirst   = (state_q == S_LOAD) && first_q;
    assign oCoreMessage = msg_q;
    assign oDigest      = digest_q;
    assign oDigestValid = dv_q;
    assign oBusy        = (state_q != S_IDLE) || lock_q;
    assign oOwner       = owner_q;
    assign oBlockCnt    = cnt_q;

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// tb/tb_sha256_core_arbiter.sv - directed vector bench for sha256_core_arbiter (default build)
module tb_sha256_core_arbiter;

    logic         iClk;
    logic         iReset;
    logic [1:0]   iReqValid;
    logic [511:0] iReqBlock0;
    logic [511:0] iReqBlock1;
    logic [1:0]   iReqLast;
    logic [1:0]   oReqReady;
    logic         oCoreLoad;
    logic [511:0] oCoreMessage;
    logic         oCoreFirst;
    logic         iCoreDone;
    logic [255:0] iCoreDigest;
    logic [255:0] oDigest;
    logic [1:0]   oDigestValid;
    logic         oBusy;
    logic         oOwner;
    logic [15:0]  oBlockCnt;

    sha256_core_arbiter #(.TIMEOUT_CYCLES(256)) dut (
        .iClk         (iClk),
        .iReset       (iReset),
        .iReqValid    (iReqValid),
        .iReqBlock0   (iReqBlock0),
        .iReqBlock1   (iReqBlock1),
        .iReqLast     (iReqLast),
        .oReqReady    (oReqReady),
        .oCoreLoad    (oCoreLoad),
        .oCoreMessage (oCoreMessage),
        .oCoreFirst   (oCoreFirst),
        .iCoreDone    (iCoreDone),
        .iCoreDigest  (iCoreDigest),
        .oDigest      (oDigest),
        .oDigestValid (oDigestValid),
        .oBusy        (oBusy),
        .oOwner       (oOwner),
        .oBlockCnt    (oBlockCnt)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    int n_total = 0;
    int n_pass  = 0;
    logic [255:0] last_digest;

    typedef struct {
        logic [1:0] valid;
        bit         grant;
        int         gap;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [511:0] mk_blk(input int req, input int idx);
        logic [31:0] w;
        w = 32'hB000_0000 | 32'(req << 16) | 32'(idx);
        return {16{w}};
    endfunction

    function automatic logic [255:0] mk_dg(input int idx);
        logic [31:0] w;
        w = 32'hD000_0000 | 32'(idx);
        return {8{w}};
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, " ready"},  oReqReady,    2'b00);
        chk({tag, " load"},   oCoreLoad,    1'b0);
        chk({tag, " first"},  oCoreFirst,   1'b0);
        chk({tag, " dv"},     oDigestValid, 2'b00);
        chk({tag, " busy"},   oBusy,        1'b0);
        chk({tag, " owner"},  oOwner,       1'b1);
        chk({tag, " blkcnt"}, oBlockCnt,    16'd0);
        chk({tag, " digest"}, oDigest,      256'd0);
        chk({tag, " msg"},    oCoreMessage, 512'd0);
    endtask

    // Presents blocks in IDLE, checks the grant, then checks the LOAD cycle; returns in LOAD.
    task automatic accept_and_load(input logic [1:0] valid, input logic [1:0] last,
                                   input logic [511:0] b0, input logic [511:0] b1,
                                   input bit exp_g, input bit exp_first,
                                   input logic [15:0] exp_cnt, input string tag);
        iReqValid  = valid;
        iReqBlock0 = b0;
        iReqBlock1 = b1;
        iReqLast   = last;
        #1;
        chk({tag, " ready"}, oReqReady, 2'b01 << exp_g);
        tick();
        chk({tag, " load"},      oCoreLoad,    1'b1);
        chk({tag, " first"},     oCoreFirst,   exp_first);
        chk({tag, " msg"},       oCoreMessage, exp_g ? b1 : b0);
        chk({tag, " owner"},     oOwner,       exp_g);
        chk({tag, " blkcnt"},    oBlockCnt,    exp_cnt);
        chk({tag, " load_hold"}, oReqReady,    2'b00);
        iReqValid[exp_g] = 1'b0;
    endtask

    // From LOAD: wait gap RUN cycles, pulse done, return in the cycle the digest pulse should show.
    task automatic finish_block(input int gap, input logic [255:0] dg,
                                input logic [1:0] exp_dv, input string tag);
        repeat (gap) tick();
        chk({tag, " run_ready"}, oReqReady, 2'b00);
        chk({tag, " run_load"},  oCoreLoad, 1'b0);
        iCoreDone   = 1'b1;
        iCoreDigest = dg;
        tick();
        iCoreDone = 1'b0;
        if (exp_dv != 2'b00) last_digest = dg;
        chk({tag, " dv"},     oDigestValid, exp_dv);
        chk({tag, " digest"}, oDigest,      last_digest);
    endtask

    initial begin
        iReset      = 1'b1;
        iReqValid   = 2'b00;
        iReqBlock0  = '0;
        iReqBlock1  = '0;
        iReqLast    = 2'b00;
        iCoreDone   = 1'b0;
        iCoreDigest = '0;
        last_digest = '0;

        vecs[0] = '{2'b11, 1'b0, 3};
        vecs[1] = '{2'b11, 1'b1, 3};
        vecs[2] = '{2'b01, 1'b0, 63};
        vecs[3] = '{2'b11, 1'b1, 2};
        vecs[4] = '{2'b10, 1'b1, 1};
        vecs[5] = '{2'b11, 1'b0, 5};
        vecs[6] = '{2'b10, 1'b1, 2};

        tick();
        tick();
        check_reset_state("reset0");
        iReset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            accept_and_load(vecs[i].valid, 2'b11, mk_blk(0, i), mk_blk(1, i),
                            vecs[i].grant, 1'b1, 16'd1, tag);
            iReqValid = 2'b00;
            finish_block(vecs[i].gap, mk_dg(i), 2'b01 << vecs[i].grant, tag);
            tick();
            chk({tag, " dv_clear"}, oDigestValid, 2'b00);
            chk({tag, " idle_busy"}, oBusy, 1'b0);
        end

        // Three-block message on req0 while req1 waits throughout.
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        last_digest = '0;
        accept_and_load(2'b11, 2'b00, mk_blk(0, 20), mk_blk(1, 20), 1'b0, 1'b1, 16'd1, "mb1");
        finish_block(3, mk_dg(20), 2'b00, "mb1");
        chk("mb1 locked_busy", oBusy, 1'b1);
        chk("mb1 locked_ready", oReqReady, 2'b00);
        tick();
        chk("mb1 locked_ready2", oReqReady, 2'b00);
        chk("mb1 locked_load", oCoreLoad, 1'b0);
        accept_and_load(2'b11, 2'b00, mk_blk(0, 21), mk_blk(1, 21), 1'b0, 1'b0, 16'd2, "mb2");
        finish_block(2, mk_dg(21), 2'b00, "mb2");
        accept_and_load(2'b11, 2'b01, mk_blk(0, 22), mk_blk(1, 22), 1'b0, 1'b0, 16'd3, "mb3");
        finish_block(4, mk_dg(22), 2'b01, "mb3");
        chk("mb3 req1_ready", oReqReady, 2'b10);
        accept_and_load(2'b10, 2'b11, mk_blk(0, 23), mk_blk(1, 23), 1'b1, 1'b1, 16'd1, "mb4");
        iReqValid = 2'b00;
        finish_block(2, mk_dg(23), 2'b10, "mb4");
        tick();

        // Reset in the middle of a two-block message.
        accept_and_load(2'b01, 2'b00, mk_blk(0, 30), mk_blk(1, 30), 1'b0, 1'b1, 16'd1, "rst");
        tick();
        iReqValid = 2'b01;
        iReset    = 1'b1;
        tick();
        check_reset_state("rst_mid");
        iReset = 1'b0;
        last_digest = '0;
        #1;
        chk("rst after_ready", oReqReady, 2'b01);
        accept_and_load(2'b01, 2'b01, mk_blk(0, 31), mk_blk(1, 31), 1'b0, 1'b1, 16'd1, "rst2");
        finish_block(2, mk_dg(31), 2'b01, "rst2");
        tick();

        // Done pulses outside RUN are ignored.
        iCoreDone   = 1'b1;
        iCoreDigest = mk_dg(99);
        tick();
        iCoreDone = 1'b0;
        chk("spur_idle dv", oDigestValid, 2'b00);
        chk("spur_idle digest", oDigest, last_digest);
        chk("spur_idle busy", oBusy, 1'b0);
        chk("spur_idle load", oCoreLoad, 1'b0);
        accept_and_load(2'b01, 2'b01, mk_blk(0, 40), mk_blk(1, 40), 1'b0, 1'b1, 16'd1, "spur_load");
        iCoreDone   = 1'b1;
        iCoreDigest = mk_dg(98);
        tick();
        iCoreDone = 1'b0;
        chk("spur_load dv", oDigestValid, 2'b00);
        chk("spur_load busy", oBusy, 1'b1);
        chk("spur_load digest", oDigest, last_digest);
        finish_block(1, mk_dg(41), 2'b01, "spur_load");
        tick();
        chk("end busy", oBusy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
